// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: instruction sequencer and small register file that sits
// in front of the 8-bit ALU. It takes one reg-reg instruction per 4 cycles,
// presents the operands with the enable low for a cycle, then pulses the
// enable and writes the ALU result back to the destination register.
module alu_issue_ctrl #(
  parameter int NREG = 4,
  parameter int DW   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [7:0]              instr,
  input  logic                    ld_en,
  input  logic [$clog2(NREG)-1:0] ld_addr,
  input  logic [DW-1:0]           ld_data,
  input  logic [$clog2(NREG)-1:0] rd_addr,
  output logic [DW-1:0]           rd_data,
  output logic                    alu_sel,
  output logic [2:0]              alu_order,
  output logic [DW-1:0]           reg_1,
  output logic [DW-1:0]           reg_2,
  input  logic [DW-1:0]           alu_out,
  output logic                    done,
  output logic                    err,
  output logic                    zero
);

  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPER = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [DW-1:0] rf [NREG];
  logic [AW-1:0] rd_q;
  logic          err_q;

  // Instruction fields; bit 0 carries no meaning.
  logic [2:0]    op;
  logic [AW-1:0] f_rd;
  logic [AW-1:0] f_rs;
  logic          illegal;
  logic          accept;
  logic          unused_bit;

  assign op         = instr[7:5];
  assign f_rd       = instr[4:3];
  assign f_rs       = instr[2:1];
  assign illegal    = (op == 3'b110) || (op == 3'b111);
  assign accept     = (state == IDLE) && instr_valid;
  assign unused_bit = instr[0];

  // Combinational observation port.
  assign rd_data = rf[rd_addr];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: illegal opcodes skip straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (instr_valid) state_next = illegal ? DONE : OPER;
      OPER: state_next = EXEC;
      EXEC: state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state.
  always_comb begin
    instr_ready = 1'b0;
    alu_sel     = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      IDLE: instr_ready = 1'b1;
      EXEC: alu_sel     = 1'b1;
      DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

  // Operand snapshot at acceptance; held after completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_order <= '0;
      reg_1     <= '0;
      reg_2     <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      err_q <= illegal;
      if (!illegal) begin
        alu_order <= op;
        reg_1     <= rf[f_rd];
        reg_2     <= rf[f_rs];
        rd_q      <= f_rd;
      end
    end
  end

  // Register file: the writeback is placed after the direct load so that it
  // takes priority when both target the same register on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (ld_en)          rf[ld_addr] <= ld_data;
      if (state == EXEC)  rf[rd_q]    <= alu_out;
    end
  end

  // Sticky zero flag, updated only by ALU writebacks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              zero <= 1'b0;
    else if (state == EXEC)  zero <= (alu_out == '0);
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencer and 4x8-bit register file sitting directly upstream of the 8-bit ALU.
- Accepts one register-to-register instruction through a valid/ready handshake and reads both operands from its register file.
- Presents operands and opcode to the ALU with the ALU enable held low, then raises the enable. It captures the ALU result and writes it back to the destination register.
- Also provides a direct load port and a combinational read port for initialising and observing registers.

Parameters:
- NREG, 4, number of 8-bit registers; fixed at 4 (2-bit addresses).
- DW, 8, datapath width; must match the ALU width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  block can accept an instruction; high only in IDLE.
- instr  in  8  instruction: [7:5] opcode, [4:3] rd (dest and source 1), [2:1] rs (source 2), [0] ignored.
- ld_en  in  1  direct register write strobe.
- ld_addr  in  2  direct write address.
- ld_data  in  8  direct write data.
- rd_addr  in  2  observation read address.
- rd_data  out  8  combinational register-file read, rf[rd_addr].
- alu_sel  out  1  ALU enable.
- alu_order  out  3  ALU opcode.
- reg_1  out  8  ALU operand 1, rf[rd].
- reg_2  out  8  ALU operand 2, rf[rs].
- alu_out  in  8  ALU result.
- done  out  1  one-cycle pulse when an instruction retires.
- err  out  1  one-cycle pulse, coincident with done, for an illegal opcode.
- zero  out  1  sticky flag: last written-back result was 0.

Behaviour:
- Reset state:
  - FSM in IDLE.
  - All registers rf[0..3] = 0.
  - alu_sel = 0, alu_order = 0, reg_1 = 0, reg_2 = 0.
  - done = 0, err = 0, zero = 0.
  - instr_ready = 1.
- Reset asserted mid-instruction aborts it immediately. No writeback occurs and outputs return to their reset values.
- FSM states: IDLE, OPER, EXEC, DONE.
- IDLE:
  - Acceptance happens on a clock edge where instr_valid = 1.
  - Legal opcodes are 000-101. On acceptance of a legal opcode, register alu_order = opcode, reg_1 = rf[rd], reg_2 = rf[rs], latch rd, then go to OPER.
  - Illegal opcodes are 110 and 111. On acceptance, go to DONE with err = 1. Nothing is written back, zero is unchanged, and alu_sel stays 0.
- OPER (1 cycle):
  - alu_sel = 0.
  - Operands and opcode are stable. The ALU evaluates only on an alu_sel/alu_order change, so its inputs must settle before enable.
- EXEC (1 cycle):
  - alu_sel = 1.
  - On the closing edge: rf[rd] <= alu_out, zero <= (alu_out == 0), go to DONE.
- DONE (1 cycle):
  - done = 1; err = 1 only on the illegal path.
  - alu_sel = 0.
  - Next state is IDLE.
- Latency: accept at edge 0; OPER in cycle 1; EXEC in cycle 2; writeback at edge 3; done high in cycle 3; instr_ready high again in cycle 4.
- Throughput: one instruction per 4 cycles.
- instr_ready is combinational from the state (IDLE only). instr_valid is ignored outside IDLE.
- reg_1, reg_2 and alu_order hold their last values after completion. Only alu_sel returns to 0.
- Operands are snapshot at acceptance. An ld_en write during OPER or EXEC does not change in-flight reg_1 or reg_2.
- ld_en is honoured in every state.
  - If ld_en collides with the EXEC writeback at the same edge and the same address, the ALU writeback wins.
  - If the addresses differ, both writes occur.
  - ld_en does not affect zero.
- Operation with rd == rs is legal: both operands come from the same register.
- Arithmetic wraps modulo 256 inside the ALU; this block adds no carry or overflow flag.
- rd_data reflects a write from the cycle after that write's edge.

Test Plan:
1. Reset, then load rf0 = 8'h12 and rf1 = 8'h34. Issue ADD rd=0, rs=1 (instr 8'h82). Required: reg_1 = 8'h12 and reg_2 = 8'h34 in OPER; alu_sel = 1 only in cycle 2; rf0 = 8'h46 read via rd_data; done pulses at cycle 3; instr_ready returns in cycle 4.
2. Load rf2 = 8'h05 and rf3 = 8'h05. Issue SUB rd=2, rs=3. Required: rf2 = 8'h00 and zero = 1. Then issue OR rd=3, rs=3. Required: rf3 = 8'h05 and zero = 0.
3. Load rf0 = 8'hF0 and rf1 = 8'h20. Issue ADD rd=0, rs=1. Required: rf0 = 8'h10 (wrap), no error.
4. Issue opcode 110 (instr 8'hC0). Required: done = 1 and err = 1 in the cycle after acceptance; alu_sel never rises; all registers and zero unchanged.
5. During EXEC of AND rd=1 (rf1 = 8'hFF, rf0 = 8'h0F), pulse ld_en with ld_addr = 1 and ld_data = 8'hAA at the writeback edge. Required: rf1 = 8'h0F (writeback wins). Repeat with ld_addr = 2. Required: rf2 = 8'hAA and rf1 = 8'h0F.
6. Hold instr_valid high during OPER, EXEC and DONE. Required: no extra acceptance. Assert rst_n = 0 mid-EXEC. Required: done never pulses; all registers read 0 after reset.
